// File: rtl/tpu_seq_pkg.sv
// rtl/tpu_seq_pkg.sv - shared state encoding, default sizes and counter-width helper for matmul_sequencer
package tpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        FEED   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ROW_W  = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_WR_LAT = 32;

    // One spare bit above rows+log2(width) so the longest write window cannot wrap.
    function automatic int cnt_width(input int row_w, input int width);
        return row_w + $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_window.sv
// rtl/seq_window.sv - loadable delay/length counter producing one registered active window
module seq_window #(
    parameter int CW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] len,
    output logic          active,
    output logic          last
);

    logic [CW-1:0] dly;
    logic [CW-1:0] rem;
    logic [CW-1:0] d_src;
    logic [CW-1:0] l_src;

    // A load takes effect on the same edge, so the window opens delay cycles after the load cycle + 1.
    assign d_src = load ? delay : dly;
    assign l_src = load ? len : rem;
    assign last  = active && (dly == '0) && (rem == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            dly    <= '0;
            rem    <= '0;
        end else if (d_src != '0) begin
            active <= 1'b0;
            dly    <= d_src - CW'(1);
            rem    <= l_src;
        end else if (l_src != '0) begin
            active <= 1'b1;
            dly    <= '0;
            rem    <= l_src - CW'(1);
        end else begin
            active <= 1'b0;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - systolic matmul phase scheduler; SEQ_WT_REUSE_EN adds reuse_wt to skip weight load
module matmul_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] wt_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
`ifdef SEQ_WT_REUSE_EN
    input  logic              reuse_wt,
`endif
    output logic              busy,
    output logic              done,
    output logic              wt_active,
    output logic              rd_active,
    output logic              wr_active,
    output logic [ADDR_W-1:0] wt_addr_base,
    output logic [ADDR_W-1:0] rd_addr_base,
    output logic [ADDR_W-1:0] wr_addr_base
);

    localparam int            CW       = cnt_width(ROW_W, WIDTH);
    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0] WR_LAT_C = CW'(WR_LAT);
    localparam logic [CW-1:0] ZERO_C   = '0;

    seq_state_e    state;
    logic          skip_w;
    logic          launch;
    logic [CW-1:0] rows_c;
    logic [CW-1:0] wt_len;
    logic [CW-1:0] rd_dly;
    logic [CW-1:0] wr_dly;
    logic [CW-1:0] wr_len;
    logic          wt_last;
    logic          rd_last;
    logic          wr_last;

`ifdef SEQ_WT_REUSE_EN
    assign skip_w = reuse_wt;
`else
    assign skip_w = 1'b0;
`endif

    // All three windows are armed on the start edge, each with its own offset from that edge.
    assign launch = (state == IDLE) && start && (num_rows != '0);
    assign rows_c = CW'(num_rows);
    assign wt_len = skip_w ? ZERO_C : WIDTH_C;
    assign rd_dly = wt_len;
    assign wr_dly = wt_len + WR_LAT_C;
    assign wr_len = rows_c + WIDTH_C - CW'(1);

    seq_window #(.CW(CW)) u_wt_win (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .delay  (ZERO_C),
        .len    (wt_len),
        .active (wt_active),
        .last   (wt_last)
    );

    seq_window #(.CW(CW)) u_rd_win (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .delay  (rd_dly),
        .len    (rows_c),
        .active (rd_active),
        .last   (rd_last)
    );

    seq_window #(.CW(CW)) u_wr_win (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .delay  (wr_dly),
        .len    (wr_len),
        .active (wr_active),
        .last   (wr_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            wt_addr_base <= '0;
            rd_addr_base <= '0;
            wr_addr_base <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        wt_addr_base <= wt_base;
                        rd_addr_base <= in_base;
                        wr_addr_base <= out_base;
                        if (num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= skip_w ? FEED : LOAD_W;
                        end
                    end
                end
                LOAD_W: begin
                    if (wt_last) begin
                        state <= FEED;
                    end
                end
                FEED: begin
                    if (rd_last) begin
                        state <= FLUSH;
                    end
                end
                // The write window always outlasts the feed, so completion keys off its final cycle.
                FLUSH: begin
                    if (wr_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized self-checking bench for matmul_sequencer against interval-arithmetic model
module tb_matmul_sequencer;

    localparam int WIDTH  = 16;
    localparam int ROW_W  = 8;
    localparam int ADDR_W = 8;
    localparam int WR_LAT = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ROW_W-1:0]  num_rows = '0;
    logic [ADDR_W-1:0] wt_base = '0;
    logic [ADDR_W-1:0] in_base = '0;
    logic [ADDR_W-1:0] out_base = '0;
    logic              reuse_wt = 1'b0;
    logic              busy;
    logic              done;
    logic              wt_active;
    logic              rd_active;
    logic              wr_active;
    logic [ADDR_W-1:0] wt_addr_base;
    logic [ADDR_W-1:0] rd_addr_base;
    logic [ADDR_W-1:0] wr_addr_base;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(
        .WIDTH  (WIDTH),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_rows     (num_rows),
        .wt_base      (wt_base),
        .in_base      (in_base),
        .out_base     (out_base),
`ifdef SEQ_WT_REUSE_EN
        .reuse_wt     (reuse_wt),
`endif
        .busy         (busy),
        .done         (done),
        .wt_active    (wt_active),
        .rd_active    (rd_active),
        .wr_active    (wr_active),
        .wt_addr_base (wt_addr_base),
        .rd_addr_base (rd_addr_base),
        .wr_addr_base (wr_addr_base)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " wt_active"}, 32'(wt_active), 32'd0);
        chk({tag, " rd_active"}, 32'(rd_active), 32'd0);
        chk({tag, " wr_active"}, 32'(wr_active), 32'd0);
        chk({tag, " wt_addr_base"}, 32'(wt_addr_base), 32'd0);
        chk({tag, " rd_addr_base"}, 32'(rd_addr_base), 32'd0);
        chk({tag, " wr_addr_base"}, 32'(wr_addr_base), 32'd0);
    endtask

    task automatic scramble_inputs();
        num_rows = ROW_W'($urandom);
        wt_base  = ADDR_W'($urandom);
        in_base  = ADDR_W'($urandom);
        out_base = ADDR_W'($urandom);
        reuse_wt = 1'($urandom);
    endtask

    // Start is driven during relative cycle 0; each later cycle k is checked against the expected windows.
    task automatic run_job(input int n, input bit reuse, input bit disturb, input int abort_at);
        logic [ADDR_W-1:0] wb;
        logic [ADDR_W-1:0] ib;
        logic [ADDR_W-1:0] ob;
        bit skip;
        int t0;
        int wr_s;
        int wr_e;
        int dn;
        wb = ADDR_W'($urandom);
        ib = ADDR_W'($urandom);
        ob = ADDR_W'($urandom);
`ifdef SEQ_WT_REUSE_EN
        skip = reuse;
`else
        skip = 1'b0;
`endif
        t0   = skip ? 1 : WIDTH + 1;
        wr_s = t0 + WR_LAT;
        wr_e = wr_s + n + WIDTH - 2;
        dn   = (n == 0) ? 1 : wr_e + 1;
        @(negedge clk);
        start    = 1'b1;
        num_rows = n[ROW_W-1:0];
        wt_base  = wb;
        in_base  = ib;
        out_base = ob;
        reuse_wt = reuse;
        for (int k = 1; k <= dn + 1; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(k <= dn));
            chk("done", 32'(done), 32'(k == dn));
            chk("wt_active", 32'(wt_active), 32'(n != 0 && !skip && k <= WIDTH));
            chk("rd_active", 32'(rd_active), 32'(n != 0 && k >= t0 && k <= t0 + n - 1));
            chk("wr_active", 32'(wr_active), 32'(n != 0 && k >= wr_s && k <= wr_e));
            if (k <= dn) begin
                chk("wt_addr_base", 32'(wt_addr_base), 32'(wb));
                chk("rd_addr_base", 32'(rd_addr_base), 32'(ib));
                chk("wr_addr_base", 32'(wr_addr_base), 32'(ob));
            end
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk_all_zero("async abort");
                start = 1'b0;
                return;
            end
            start = disturb && (k == 5 || k == 30) && (k < dn);
            scramble_inputs();
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        run_job(4, 1'b0, 1'b0, 0);
        run_job(0, 1'b0, 1'b0, 0);
        run_job(40, 1'b0, 1'b0, 0);
        run_job(4, 1'b0, 1'b1, 0);
        run_job(255, 1'b0, 1'b1, 0);

        run_job(4, 1'b0, 1'b0, 18);
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("held reset");
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset done", 32'(done), 32'd0);
        run_job(4, 1'b0, 1'b1, 0);

`ifdef SEQ_WT_REUSE_EN
        run_job(4, 1'b1, 1'b0, 0);
        run_job(0, 1'b1, 1'b0, 0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_job(int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)), 1'b1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
